// File: rtl/clk_divider_pkg.sv
// rtl/clk_divider_pkg.sv - shared constants and output-source decode for the clock divider
package clk_divider_pkg;

    localparam int CLK_DIV_BITS_DEFAULT = 32;

    typedef enum logic [1:0] {
        OUT_OFF    = 2'd0,
        OUT_BYPASS = 2'd1,
        OUT_SQUARE = 2'd2,
        OUT_PULSE  = 2'd3
    } out_sel_e;

    // Disable dominates; bypass ignores the pulse/square choice.
    function automatic out_sel_e decode_out_sel(input logic out_enable,
                                                input logic option,
                                                input logic pulse);
        out_sel_e sel;
        if (!out_enable) begin
            sel = OUT_OFF;
        end else if (!option) begin
            sel = OUT_BYPASS;
        end else if (pulse) begin
            sel = OUT_PULSE;
        end else begin
            sel = OUT_SQUARE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/clk_divider_if.sv
// rtl/clk_divider_if.sv - control and output bundle of the clock divider
interface clk_divider_if
    import clk_divider_pkg::*;
#(
    parameter int COUNTER_BITS = CLK_DIV_BITS_DEFAULT
);

    logic                    option;
    logic                    out_enable;
    logic [COUNTER_BITS-1:0] divider;
    logic                    pulse;
    logic                    clk_o;

    modport master (
        output option,
        output out_enable,
        output divider,
        output pulse,
        input  clk_o
    );

    modport slave (
        input  option,
        input  out_enable,
        input  divider,
        input  pulse,
        output clk_o
    );

endinterface

// File: rtl/clk_divider_counter.sv
// rtl/clk_divider_counter.sv - wrapping division counter with terminal-count flag
module clk_divider_counter
    import clk_divider_pkg::*;
#(
    parameter int COUNTER_BITS = CLK_DIV_BITS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic [COUNTER_BITS-1:0] divider,
    output logic                    term
);

    localparam logic [COUNTER_BITS-1:0] ONE = COUNTER_BITS'(1);

    logic [COUNTER_BITS-1:0] count_q;
    logic [COUNTER_BITS-1:0] count_d;
    logic [COUNTER_BITS-1:0] neff_m1;

    // A divider of 0 behaves as 1; >= lets a shrunk divider wrap at once.
    always_comb begin
        neff_m1 = '0;
        if (divider != '0) begin
            neff_m1 = divider - ONE;
        end
        term = (count_q >= neff_m1);
    end

    always_comb begin
        count_d = '0;
        if (run && !term) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/clk_divider.sv
// rtl/clk_divider.sv - programmable divider producing square wave, pulse train or bypassed clock
module clk_divider
    import clk_divider_pkg::*;
#(
    parameter int COUNTER_BITS = CLK_DIV_BITS_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    clk_divider_if.slave bus
);

    logic     run;
    logic     term;
    logic     tgl_q;
    logic     tgl_d;
    logic     pls_q;
    logic     pls_d;
    logic     clk_o;
    out_sel_e out_sel;

    assign run     = bus.out_enable & bus.option;
    assign out_sel = decode_out_sel(bus.out_enable, bus.option, bus.pulse);

    clk_divider_counter #(
        .COUNTER_BITS (COUNTER_BITS)
    ) u_counter (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .divider (bus.divider),
        .term    (term)
    );

    // Bypass and disable both park the shape registers at 0 so divide restarts cleanly.
    always_comb begin
        tgl_d = 1'b0;
        pls_d = 1'b0;
        if (run) begin
            tgl_d = tgl_q ^ term;
            pls_d = term;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tgl_q <= 1'b0;
            pls_q <= 1'b0;
        end else begin
            tgl_q <= tgl_d;
            pls_q <= pls_d;
        end
    end

    always_comb begin
        clk_o = 1'b0;
        case (out_sel)
            OUT_BYPASS: clk_o = clk;
            OUT_SQUARE: clk_o = tgl_q;
            OUT_PULSE:  clk_o = pls_q;
            default:    clk_o = 1'b0;
        endcase
    end

    assign bus.clk_o = clk_o;

endmodule

// File: tb/tb_clk_divider.sv
// tb/tb_clk_divider.sv - directed scoreboard bench for clk_divider
module tb_clk_divider;
    import clk_divider_pkg::*;

    localparam int W = CLK_DIV_BITS_DEFAULT;

    typedef struct {
        string tag;
        logic  val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    clk_divider_if #(.COUNTER_BITS(W)) bus ();

    clk_divider #(.COUNTER_BITS(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: clk_o=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    // After enabled edge k the square output is floor(k/N) mod 2.
    task automatic push_square(input string tag, input int n, input int k0, input int cnt);
        for (int k = k0 + 1; k <= k0 + cnt; k++) begin
            push($sformatf("%s k=%0d", tag, k), logic'((k / n) % 2));
        end
    endtask

    // After enabled edge k the pulse output is high when k is a multiple of N.
    task automatic push_pulse(input string tag, input int n, input int k0, input int cnt);
        for (int k = k0 + 1; k <= k0 + cnt; k++) begin
            push($sformatf("%s k=%0d", tag, k), logic'((k % n) == 0));
        end
    endtask

    // One sampled edge per queued expectation; the queue length bounds the wait.
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check(e.tag, bus.clk_o, e.val);
        end
    endtask

    task automatic restart(input logic opt, input logic pul, input logic [W-1:0] div);
        bus.out_enable = 1'b0;
        push("restart_off", 1'b0);
        push("restart_off", 1'b0);
        drain();
        bus.option     = opt;
        bus.pulse      = pul;
        bus.divider    = div;
        bus.out_enable = 1'b1;
    endtask

    initial begin
        reset          = 1'b1;
        bus.option     = 1'b1;
        bus.out_enable = 1'b1;
        bus.pulse      = 1'b0;
        bus.divider    = W'(10);
        #12;
        check("reset_hold", bus.clk_o, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        push_square("sq10", 10, 0, 40);
        drain();

        restart(1'b1, 1'b0, W'(10));
        push_square("pre_disable", 10, 0, 15);
        drain();
        bus.out_enable = 1'b0;
        #1;
        check("oe_drop_comb", bus.clk_o, 1'b0);
        for (int i = 0; i < 15; i++) push("disabled", 1'b0);
        drain();
        bus.out_enable = 1'b1;
        #1;
        check("reenable_low", bus.clk_o, 1'b0);
        push_square("reenable", 10, 0, 25);
        drain();

        restart(1'b1, 1'b1, W'(4));
        push_pulse("pulse4", 4, 0, 16);
        drain();

        restart(1'b1, 1'b0, W'(0));
        push_square("sq_div0", 1, 0, 8);
        drain();
        restart(1'b1, 1'b0, W'(1));
        push_square("sq_div1", 1, 0, 8);
        drain();
        restart(1'b1, 1'b1, W'(0));
        push_pulse("pl_div0", 1, 0, 6);
        drain();
        restart(1'b1, 1'b1, W'(1));
        push_pulse("pl_div1", 1, 0, 6);
        drain();

        // Shrink 10 -> 3 with count at 7: wrap on the next edge, then toggle every 3.
        restart(1'b1, 1'b0, W'(10));
        push_square("pre_shrink", 10, 0, 7);
        drain();
        bus.divider = W'(3);
        for (int j = 1; j <= 12; j++) begin
            push($sformatf("shrink j=%0d", j), logic'(((j + 2) / 3) % 2));
        end
        drain();
        bus.pulse = 1'b1;
        for (int j = 13; j <= 18; j++) begin
            push($sformatf("pulse_switch j=%0d", j), logic'((j % 3) == 1));
        end
        drain();

        restart(1'b1, 1'b0, W'(10));
        push_square("pre_bypass", 10, 0, 5);
        drain();
        bus.option = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("bypass_high", bus.clk_o, 1'b1);
            @(negedge clk);
            #1;
            check("bypass_low", bus.clk_o, 1'b0);
        end
        bus.option = 1'b1;
        push_square("after_bypass", 10, 0, 12);
        drain();

        bus.option     = 1'b0;
        bus.out_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bypass_off_hi", bus.clk_o, 1'b0);
            @(negedge clk);
            #1;
            check("bypass_off_lo", bus.clk_o, 1'b0);
        end

        restart(1'b1, 1'b0, W'(10));
        push_square("pre_reset", 10, 0, 12);
        drain();
        reset = 1'b1;
        #1;
        check("async_reset_comb", bus.clk_o, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("in_reset", bus.clk_o, 1'b0);
        end
        @(negedge clk);
        reset = 1'b0;
        push_square("post_reset", 10, 0, 22);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
